// File: rtl/selectio_align_ctrl.sv
// Per-lane ISERDES word alignment: bitslip until the training word lines up, then lock.
// Define SELECTIO_ALIGN_ERRMON_EN to add post-lock training-word error counters.

module selectio_align_lane #(
    parameter int                 SP_Mult    = 4,
    parameter logic [SP_Mult-1:0] TRAIN_PAT  = 4'b0001,
    parameter int                 LOCK_CNT   = 8,
    parameter int                 SETTLE_CYC = 3,
    parameter int                 MAX_SLIP   = 2*SP_Mult
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               train_chk,
    input  logic [SP_Mult-1:0] word,
    output logic               bitslip,
    output logic               lock,
    output logic               fail,
    output logic               busy,
    output logic [7:0]         slip_cnt,
    output logic [15:0]        err_cnt
);
    localparam int CW = (LOCK_CNT > 0) ? $clog2(LOCK_CNT + 1) : 1;
    localparam int WW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam logic [CW-1:0] LOCK_V    = CW'(LOCK_CNT);
    localparam logic [WW-1:0] WAIT_LAST = WW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CHECK, ST_SLIP, ST_WAIT, ST_LOCKED, ST_FAIL
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] match_cnt;
    logic [WW-1:0] wait_cnt;
    logic          match;
    logic          slip_at_max;

    assign match       = (word == TRAIN_PAT);
    assign slip_at_max = (int'(slip_cnt) == MAX_SLIP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // A full match count is consumed one cycle later, giving lock LOCK_CNT+1 cycles after start.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_CHECK;
        end else begin
            case (state)
                ST_CHECK: begin
                    if (match_cnt == LOCK_V) state_nxt = ST_LOCKED;
                    else if (!match)         state_nxt = slip_at_max ? ST_FAIL : ST_SLIP;
                end
                ST_SLIP: state_nxt = ST_WAIT;
                ST_WAIT: if (wait_cnt == WAIT_LAST) state_nxt = ST_CHECK;
                default: ;
            endcase
        end
    end

    always_comb begin
        bitslip = 1'b0;
        lock    = 1'b0;
        fail    = 1'b0;
        busy    = 1'b0;
        case (state)
            ST_CHECK, ST_WAIT: busy = 1'b1;
            ST_SLIP: begin
                bitslip = 1'b1;
                busy    = 1'b1;
            end
            ST_LOCKED: lock = 1'b1;
            ST_FAIL:   fail = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt <= '0;
            wait_cnt  <= '0;
            slip_cnt  <= '0;
        end else if (start) begin
            match_cnt <= '0;
            wait_cnt  <= '0;
            slip_cnt  <= '0;
        end else begin
            case (state)
                ST_CHECK: if (match_cnt != LOCK_V) match_cnt <= match ? match_cnt + 1'b1 : '0;
                ST_SLIP: begin
                    if (slip_cnt != 8'hFF) slip_cnt <= slip_cnt + 8'd1;
                    wait_cnt <= '0;
                end
                ST_WAIT: wait_cnt <= wait_cnt + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef SELECTIO_ALIGN_ERRMON_EN
    logic [15:0] err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= '0;
        else if (start)
            err_q <= '0;
        else if (state == ST_LOCKED && train_chk && !match && err_q != 16'hFFFF)
            err_q <= err_q + 16'd1;
    end

    assign err_cnt = err_q;
`else
    logic unused_train_chk;
    assign unused_train_chk = train_chk;
    assign err_cnt          = '0;
`endif
endmodule

module selectio_align_ctrl #(
    parameter int                 DW         = 4,
    parameter int                 SP_Mult    = 4,
    parameter logic [SP_Mult-1:0] TRAIN_PAT  = 4'b0001,
    parameter int                 LOCK_CNT   = 8,
    parameter int                 SETTLE_CYC = 3,
    parameter int                 MAX_SLIP   = 2*SP_Mult
) (
    input  logic                  i_fclk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [DW*SP_Mult-1:0] i_pardata,
    input  logic                  i_train_chk,
    output logic [DW-1:0]         o_bitslip,
    output logic [DW-1:0]         o_lane_lock,
    output logic [DW-1:0]         o_lane_fail,
    output logic                  o_all_lock,
    output logic                  o_busy,
    output logic [DW*8-1:0]       o_slip_cnt,
    output logic [DW*16-1:0]      o_err_cnt
);
    logic [1:0]                 rst_sync;
    logic                       rst_n;
    logic [DW*SP_Mult-1:0]      pardata_q;
    logic [DW-1:0][SP_Mult-1:0] lane_word;
    logic [DW-1:0]              lane_busy;

    // Reset asserts immediately, releases only on a clock edge.
    always_ff @(posedge i_fclk or negedge i_rst_n) begin
        if (!i_rst_n) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    always_ff @(posedge i_fclk or negedge rst_n) begin
        if (!rst_n) begin
            pardata_q  <= '0;
            o_all_lock <= 1'b0;
        end else begin
            pardata_q  <= i_pardata;
            o_all_lock <= &o_lane_lock;
        end
    end

    assign o_busy = |lane_busy;

    for (genvar k = 0; k < DW; k++) begin : g_lane
        for (genvar j = 0; j < SP_Mult; j++) begin : g_bit
            assign lane_word[k][j] = pardata_q[DW*j + k];
        end

        selectio_align_lane #(
            .SP_Mult   (SP_Mult),
            .TRAIN_PAT (TRAIN_PAT),
            .LOCK_CNT  (LOCK_CNT),
            .SETTLE_CYC(SETTLE_CYC),
            .MAX_SLIP  (MAX_SLIP)
        ) u_lane (
            .clk      (i_fclk),
            .rst_n    (rst_n),
            .start    (i_start),
            .train_chk(i_train_chk),
            .word     (lane_word[k]),
            .bitslip  (o_bitslip[k]),
            .lock     (o_lane_lock[k]),
            .fail     (o_lane_fail[k]),
            .busy     (lane_busy[k]),
            .slip_cnt (o_slip_cnt[8*k +: 8]),
            .err_cnt  (o_err_cnt[16*k +: 16])
        );
    end
endmodule

// File: tb/tb_selectio_align_ctrl.sv
// Directed bench for selectio_align_ctrl with a bitslip-rotating ISERDES model and a
// closed-form per-cycle expectation model.
`timescale 1ns/1ps

module tb_selectio_align_ctrl;
    localparam int DW = 4, SP = 4, LOCK_CNT = 8, SETTLE_CYC = 3, MAX_SLIP = 8;
    localparam logic [SP-1:0] PAT = 4'b0001;
    localparam int PER = SETTLE_CYC + 2;

    logic             i_fclk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_start = 1'b0;
    logic             i_train_chk = 1'b0;
    logic [DW*SP-1:0] i_pardata;
    logic [DW-1:0]    o_bitslip, o_lane_lock, o_lane_fail;
    logic             o_all_lock, o_busy;
    logic [DW*8-1:0]  o_slip_cnt;
    logic [DW*16-1:0] o_err_cnt;

    int nvec = 0, nerr = 0;

    // ISERDES model state: lane offset = init_off + slips seen since configure
    int init_off[DW] = '{default: 0};
    int base[DW]     = '{default: 0};
    int tot[DW]      = '{default: 0};
    logic [DW-1:0] stuck = '0, corrupt = '0;
    logic [SP-1:0] pat_v = PAT;

    // expectation model state
    int cfg_r[DW] = '{default: 0};
    logic [DW-1:0] cfg_stuck = '0;
    int m_r[DW] = '{default: 0};
    logic [DW-1:0] m_stuck = '0;
    bit   track = 0, chk_en = 0;
    int   t = 0;
    logic lock_prev = 1'b0;

    selectio_align_ctrl #(
        .DW(DW), .SP_Mult(SP), .TRAIN_PAT(PAT), .LOCK_CNT(LOCK_CNT),
        .SETTLE_CYC(SETTLE_CYC), .MAX_SLIP(MAX_SLIP)
    ) dut (
        .i_fclk(i_fclk), .i_rst_n(i_rst_n), .i_start(i_start), .i_pardata(i_pardata),
        .i_train_chk(i_train_chk), .o_bitslip(o_bitslip), .o_lane_lock(o_lane_lock),
        .o_lane_fail(o_lane_fail), .o_all_lock(o_all_lock), .o_busy(o_busy),
        .o_slip_cnt(o_slip_cnt), .o_err_cnt(o_err_cnt)
    );

    always #5 i_fclk = ~i_fclk;

    always_comb begin
        i_pardata = '0;
        for (int k = 0; k < DW; k++)
            for (int j = 0; j < SP; j++)
                i_pardata[DW*j + k] = !stuck[k] &&
                    (pat_v[(j + init_off[k] + tot[k] - base[k]) % SP] ^ (corrupt[k] && j == 1));
    end

    always @(negedge i_fclk)
        for (int k = 0; k < DW; k++)
            if (o_bitslip[k]) tot[k] <= tot[k] + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
        end
    endtask

    // Pulses every PER cycles from cycle 1; lock LOCK_CNT+1 cycles after the last settle.
    task automatic check_cycle();
        logic [DW-1:0]   eb, el, ef, eu;
        logic [DW*8-1:0] es;
        int ns, done, sc;
        eb = '0; el = '0; ef = '0; eu = '0; es = '0;
        if (track) begin
            for (int k = 0; k < DW; k++) begin
                ns   = m_stuck[k] ? MAX_SLIP : m_r[k];
                done = m_stuck[k] ? PER*MAX_SLIP + 1 : PER*m_r[k] + LOCK_CNT + 1;
                eb[k] = (t >= 1) && ((t - 1) % PER == 0) && ((t - 1) / PER < ns);
                sc = (t < 2) ? 0 : (t - 2) / PER + 1;
                if (sc > ns) sc = ns;
                es[8*k +: 8] = 8'(sc);
                el[k] = !m_stuck[k] && (t >= done);
                ef[k] = m_stuck[k] && (t >= done);
                eu[k] = (t < done);
            end
        end
        chk("bitslip", 64'(o_bitslip), 64'(eb));
        chk("lane_lock", 64'(o_lane_lock), 64'(el));
        chk("lane_fail", 64'(o_lane_fail), 64'(ef));
        chk("busy", 64'(o_busy), 64'(|eu));
        chk("slip_cnt", 64'(o_slip_cnt), 64'(es));
        chk("all_lock", 64'(o_all_lock), 64'(track ? lock_prev : 1'b0));
        if (!track) chk("err_cnt_idle", o_err_cnt, 64'h0);
        lock_prev = &el;
    endtask

    always @(posedge i_fclk) begin
        #1;
        if (!i_rst_n) track = 0;
        else if (i_start) begin
            track = 1; t = 0; m_r = cfg_r; m_stuck = cfg_stuck;
        end else if (track) t++;
        if (chk_en) check_cycle();
    end

    task automatic configure(input int r0, input int r1, input int r2, input int r3,
                             input logic [DW-1:0] stk);
        cfg_r[0] = r0; cfg_r[1] = r1; cfg_r[2] = r2; cfg_r[3] = r3;
        cfg_stuck = stk;
        stuck = stk;
        for (int k = 0; k < DW; k++) begin
            init_off[k] = (SP - cfg_r[k]) % SP;
            base[k]     = tot[k];
        end
    endtask

    // returns at the negedge following the sampling edge (t = 0)
    task automatic start_pulse();
        i_start = 1'b1;
        @(negedge i_fclk);
        i_start = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_lock", 64'(o_lane_lock), 64'h0);
        chk("rst_slip", 64'(o_slip_cnt), 64'h0);
        chk_en = 1;
        repeat (3) @(negedge i_fclk);
        i_rst_n = 1'b1;
        repeat (4) @(negedge i_fclk);

        // all lanes aligned
        configure(0, 0, 0, 0, 4'b0000);
        start_pulse();
        repeat (8) @(negedge i_fclk);
        chk("a_lock_t8", 64'(o_lane_lock), 64'h0);
        @(negedge i_fclk);
        chk("a_lock_t9", 64'(o_lane_lock), 64'hF);
        chk("a_all_t9", 64'(o_all_lock), 64'h0);
        @(negedge i_fclk);
        chk("a_all_t10", 64'(o_all_lock), 64'h1);
        chk("a_busy_t10", 64'(o_busy), 64'h0);
        chk("a_slipcnt", 64'(o_slip_cnt), 64'h0);
        repeat (5) @(negedge i_fclk);

        // restart while locked
        start_pulse();
        chk("b_lock_t0", 64'(o_lane_lock), 64'h0);
        repeat (9) @(negedge i_fclk);
        chk("b_lock_t9", 64'(o_lane_lock), 64'hF);
        repeat (3) @(negedge i_fclk);

        // lane 2 needs three rotations
        configure(0, 0, 3, 0, 4'b0000);
        start_pulse();
        @(negedge i_fclk);
        chk("c_slip_t1", 64'(o_bitslip), 64'h4);
        repeat (5) @(negedge i_fclk);
        chk("c_slip_t6", 64'(o_bitslip), 64'h4);
        repeat (5) @(negedge i_fclk);
        chk("c_slip_t11", 64'(o_bitslip), 64'h4);
        repeat (5) @(negedge i_fclk);
        chk("c_slip_t16", 64'(o_bitslip), 64'h0);
        repeat (10) @(negedge i_fclk);
        chk("c_lock", 64'(o_lane_lock), 64'hF);
        chk("c_slipcnt", 64'(o_slip_cnt), 64'h0003_0000);

        // lane 0 stuck at zero
        configure(0, 0, 0, 0, 4'b0001);
        start_pulse();
        repeat (50) @(negedge i_fclk);
        chk("d_fail", 64'(o_lane_fail), 64'h1);
        chk("d_lock", 64'(o_lane_lock), 64'hE);
        chk("d_all", 64'(o_all_lock), 64'h0);
        chk("d_slipcnt", 64'(o_slip_cnt), 64'h0000_0008);
        chk("d_busy", 64'(o_busy), 64'h0);

        // reset during lane 3's third slip cycle
        configure(0, 0, 0, 3, 4'b0000);
        start_pulse();
        repeat (11) @(negedge i_fclk);
        chk("e_slip_pre", 64'(o_bitslip), 64'h8);
        chk("e_lock_pre", 64'(o_lane_lock), 64'h7);
        chk("e_slipcnt_pre", 64'(o_slip_cnt), 64'h0200_0000);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("e_slip_rst", 64'(o_bitslip), 64'h0);
        chk("e_lock_rst", 64'(o_lane_lock), 64'h0);
        chk("e_slipcnt_rst", 64'(o_slip_cnt), 64'h0);
        chk("e_all_rst", 64'(o_all_lock), 64'h0);
        repeat (3) @(negedge i_fclk);
        i_rst_n = 1'b1;
        repeat (10) @(negedge i_fclk);
        chk("e_idle_slipcnt", 64'(o_slip_cnt), 64'h0);

        // error monitor: five corrupted words on lane 1 while locked
        configure(0, 0, 0, 0, 4'b0000);
        start_pulse();
        repeat (15) @(negedge i_fclk);
        i_train_chk = 1'b1;
        corrupt = 4'b0010;
        repeat (5) @(negedge i_fclk);
        corrupt = 4'b0000;
        repeat (3) @(negedge i_fclk);
        i_train_chk = 1'b0;
`ifdef SELECTIO_ALIGN_ERRMON_EN
        chk("f_errcnt", o_err_cnt, 64'h0000_0000_0005_0000);
`else
        chk("f_errcnt", o_err_cnt, 64'h0);
`endif
        chk("f_lock", 64'(o_lane_lock), 64'hF);
        @(negedge i_fclk);
        chk_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
